// File: rtl/uart_csr_fifo_pkg.sv
// uart_defs: shared definitions for the UART CSR block.
//   - register offsets within the 4 KB window
//   - version constants reported by the VERSION register
//   - REGState_t bus FSM state type and its state constants
//   - Config_t layout of the CONTROL register
//   - bit positions inside RXSTATUS / TXSTATUS
//   - AXI response codes
package uart_defs;

  localparam logic [11:0] OFF_DIVIDER   = 12'h000;
  localparam logic [11:0] OFF_RXDATA    = 12'h004;
  localparam logic [11:0] OFF_RXSTATUS  = 12'h008;
  localparam logic [11:0] OFF_RXIRQMASK = 12'h00C;
  localparam logic [11:0] OFF_TXDATA    = 12'h010;
  localparam logic [11:0] OFF_TXSTATUS  = 12'h014;
  localparam logic [11:0] OFF_TXIRQMASK = 12'h018;
  localparam logic [11:0] OFF_CONTROL   = 12'h01C;
  localparam logic [11:0] OFF_VERSION   = 12'h020;
  localparam logic [11:0] OFF_FIFOLVL   = 12'h024;

  // Major bumped from 1 (the previous CSR block without FIFOs) to 2.
  localparam logic [7:0]  VERSION_MAJOR   = 8'd2;
  localparam logic [7:0]  VERSION_MINOR   = 8'd0;
  localparam logic [15:0] VERSION_PATCHES = 16'd0;

  typedef logic [1:0] REGState_t;
  localparam REGState_t REG_RST   = 2'd0;
  localparam REGState_t REG_IDLE  = 2'd1;
  localparam REGState_t REG_BRESP = 2'd2;
  localparam REGState_t REG_RRESP = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_SIMPLEX    = 2'd1,
    MODE_HALFDUPLEX = 2'd2,
    MODE_FULLDUPLEX = 2'd3
  } uart_mode_t;

  typedef struct packed {
    logic [28:0] reserved;
    logic        master;
    uart_mode_t  mode;
  } Config_t;

  localparam int RX_NOT_EMPTY_BIT = 0;
  localparam int RX_FULL_BIT      = 1;
  localparam int RX_OVERRUN_BIT   = 2;
  localparam int TX_EMPTY_BIT     = 0;
  localparam int TX_FULL_BIT      = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4.sv
// axi4: single-beat AXI4 register-port bundle.
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where both valid and ready are high; the source holds valid and payload
// stable until that edge.
// Modports: slave (register block side), master (initiator side).
interface axi4 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;
  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic                ar_valid;
  logic                ar_ready;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
           ar_id, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_valid
  );

  modport master (
    output aw_id, aw_addr, aw_valid, w_data, w_strb, w_last, w_valid, b_ready,
           ar_id, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_valid
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO, DEPTH a power of two (>= 2).
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data (head,
// valid while !empty), full, empty, level (0..DEPTH inclusive).
// A push while full is dropped even if a pop happens in the same cycle;
// a pop while empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem[rd_ptr];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_csr_fifo.sv
// uart_csr_fifo: AXI4 register window for a UART with TX and RX byte FIFOs.
// Optional feature macro: UART_CSR_IRQ_EN (IRQ mask registers + registered irq_o).
// Ports: clk, rst_n (async active-low), bus (axi4.slave), divider_q_o,
// uart_config_q_o (CONTROL), tx_enable_o / rx_enable_o (mode decode),
// tx_d_o / tx_d_valid_o / tx_d_ready_i (TX FIFO head to the transmitter),
// rx_d_i / rx_d_valid_i / rx_d_ready_o (receiver into RX FIFO), irq_o.
// All side effects (register writes, FIFO push/pop) happen only on the
// address-acceptance edge; responses are captured there and held until ready.
module uart_csr_fifo import uart_defs::*; #(
  parameter logic [31:0] REG_ADDR_MAP = 32'h0,
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  axi4.slave          bus,
  output logic [31:0] divider_q_o,
  output Config_t     uart_config_q_o,
  output logic        tx_enable_o,
  output logic        rx_enable_o,
  output logic [7:0]  tx_d_o,
  output logic        tx_d_valid_o,
  input  logic        tx_d_ready_i,
  input  logic [7:0]  rx_d_i,
  input  logic        rx_d_valid_i,
  output logic        rx_d_ready_o,
  output logic        irq_o
);
  REGState_t state_q, state_d;
  logic wr_req, wr_acc, rd_acc, wr_in_win, rd_in_win;
  logic [11:0] wr_off, rd_off;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;
  logic divider_we, control_we, tx_push, ovr_clr, rxmask_we, txmask_we, rx_pop;
  logic [31:0] divider_q;
  Config_t     config_q;
  logic [7:0]  tx_last_q, rx_head;
  logic        overrun_q, tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(TX_DEPTH):0] tx_level;
  logic [$clog2(RX_DEPTH):0] rx_level;
  logic [31:0] rx_status, tx_status, fifo_lvl;
  logic [2:0]  rx_mask;
  logic [1:0]  tx_mask;
  logic [bus.ID_W-1:0] b_id_q, r_id_q;
  logic [1:0]  b_resp_q, r_resp_q;
  logic [31:0] r_data_q;

  // A complete write (AW and W together) beats a read in IDLE.
  assign wr_req    = bus.aw_valid & bus.w_valid;
  assign wr_acc    = (state_q == REG_IDLE) & wr_req;
  assign rd_acc    = (state_q == REG_IDLE) & ~wr_req & bus.ar_valid;
  assign wr_in_win = (bus.aw_addr[31:12] == REG_ADDR_MAP[31:12]);
  assign rd_in_win = (bus.ar_addr[31:12] == REG_ADDR_MAP[31:12]);
  assign wr_off    = bus.aw_addr[11:0];
  assign rd_off    = bus.ar_addr[11:0];

  assign bus.aw_ready = wr_acc;
  assign bus.w_ready  = wr_acc;
  assign bus.ar_ready = rd_acc;
  assign bus.b_valid  = (state_q == REG_BRESP);
  assign bus.r_valid  = (state_q == REG_RRESP);
  assign bus.b_id     = b_id_q;
  assign bus.b_resp   = b_resp_q;
  assign bus.r_id     = r_id_q;
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.r_last   = 1'b1;

  assign rx_status = {29'h0, overrun_q, rx_full, ~rx_empty};
  assign tx_status = {30'h0, tx_full, tx_empty};
  assign fifo_lvl  = {16'(rx_level), 16'(tx_level)};

  always_comb begin
    wr_resp    = RESP_OKAY;
    divider_we = 1'b0;
    control_we = 1'b0;
    tx_push    = 1'b0;
    ovr_clr    = 1'b0;
    rxmask_we  = 1'b0;
    txmask_we  = 1'b0;
    if (!wr_in_win) begin
      wr_resp = RESP_SLVERR;
    end else begin
      case (wr_off)
        OFF_DIVIDER:   divider_we = 1'b1;
        OFF_RXSTATUS:  ovr_clr    = bus.w_data[RX_OVERRUN_BIT];
        OFF_RXIRQMASK: rxmask_we  = 1'b1;
        OFF_TXDATA: begin
          tx_push = 1'b1;
          if (tx_full) wr_resp = RESP_SLVERR;
        end
        OFF_TXIRQMASK: txmask_we  = 1'b1;
        OFF_CONTROL:   control_we = 1'b1;
        // Read-only registers and unmapped offsets.
        default:       wr_resp    = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'h0;
    rd_resp = RESP_OKAY;
    rx_pop  = 1'b0;
    if (!rd_in_win) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (rd_off)
        OFF_DIVIDER:   rd_data = divider_q;
        OFF_RXDATA: begin
          if (rx_empty) begin
            rd_resp = RESP_SLVERR;
          end else begin
            rd_data = {24'h0, rx_head};
            rx_pop  = 1'b1;
          end
        end
        OFF_RXSTATUS:  rd_data = rx_status;
        OFF_RXIRQMASK: rd_data = {29'h0, rx_mask};
        OFF_TXDATA:    rd_data = {24'h0, tx_last_q};
        OFF_TXSTATUS:  rd_data = tx_status;
        OFF_TXIRQMASK: rd_data = {30'h0, tx_mask};
        OFF_CONTROL:   rd_data = config_q;
        OFF_VERSION:   rd_data = {VERSION_MAJOR, VERSION_MINOR, VERSION_PATCHES};
        OFF_FIFOLVL:   rd_data = fifo_lvl;
        default:       rd_resp = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      REG_RST:   state_d = REG_IDLE;
      REG_IDLE:  state_d = wr_acc ? REG_BRESP : (rd_acc ? REG_RRESP : REG_IDLE);
      REG_BRESP: state_d = bus.b_ready ? REG_IDLE : REG_BRESP;
      REG_RRESP: state_d = bus.r_ready ? REG_IDLE : REG_RRESP;
      default:   state_d = REG_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REG_RST;
      b_id_q    <= '0;
      b_resp_q  <= RESP_OKAY;
      r_id_q    <= '0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= 32'h0;
      divider_q <= 32'h0;
      config_q  <= '0;
      tx_last_q <= 8'h0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_acc) begin
        b_id_q   <= bus.aw_id;
        b_resp_q <= wr_resp;
        if (divider_we)         divider_q <= bus.w_data;
        if (control_we)         config_q  <= Config_t'(bus.w_data);
        if (tx_push && !tx_full) tx_last_q <= bus.w_data[7:0];
      end
      if (rd_acc) begin
        r_id_q   <= bus.ar_id;
        r_resp_q <= rd_resp;
        r_data_q <= rd_data;
      end
      // A new overflow in the clearing cycle keeps the flag set.
      if (rx_d_valid_i && rx_full)  overrun_q <= 1'b1;
      else if (wr_acc && ovr_clr)   overrun_q <= 1'b0;
    end
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(wr_acc & tx_push), .push_data(bus.w_data[7:0]),
    .pop(tx_d_valid_o & tx_d_ready_i), .pop_data(tx_d_o),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_d_valid_i), .push_data(rx_d_i),
    .pop(rd_acc & rx_pop), .pop_data(rx_head),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign tx_d_valid_o    = ~tx_empty;
  assign rx_d_ready_o    = 1'b1;
  assign divider_q_o     = divider_q;
  assign uart_config_q_o = config_q;
  assign tx_enable_o = (config_q.mode == MODE_FULLDUPLEX) | (config_q.mode == MODE_HALFDUPLEX) |
                       ((config_q.mode == MODE_SIMPLEX) & config_q.master);
  assign rx_enable_o = (config_q.mode == MODE_FULLDUPLEX) | (config_q.mode == MODE_HALFDUPLEX) |
                       ((config_q.mode == MODE_SIMPLEX) & ~config_q.master);

`ifdef UART_CSR_IRQ_EN
  logic [2:0] rx_mask_q;
  logic [1:0] tx_mask_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_mask_q <= 3'h0;
      tx_mask_q <= 2'h0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_acc && rxmask_we) rx_mask_q <= bus.w_data[2:0];
      if (wr_acc && txmask_we) tx_mask_q <= bus.w_data[1:0];
      irq_q <= (|(rx_mask_q & rx_status[2:0])) | (|(tx_mask_q & tx_status[1:0]));
    end
  end

  assign rx_mask = rx_mask_q;
  assign tx_mask = tx_mask_q;
  assign irq_o   = irq_q;
`else
  logic unused_mask_we;
  assign unused_mask_we = rxmask_we | txmask_we;
  assign rx_mask = 3'h0;
  assign tx_mask = 2'h0;
  assign irq_o   = 1'b0;
`endif

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.w_strb, bus.w_last};
endmodule

// File: tb/tb_uart_csr_fifo.sv
// tb_uart_csr_fifo: directed bench for uart_csr_fifo (window base 0x4000_0000,
// 16-entry FIFOs). A vector table covers single register accesses; hand-written
// sequences cover FIFO fill/overflow, overrun, arbitration, IRQ and reset.
module tb_uart_csr_fifo;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] divider_q_o, cfg_q;
  logic        tx_enable_o, rx_enable_o, tx_d_valid_o, tx_d_ready_i, rx_d_valid_i;
  logic        rx_d_ready_o, irq_o;
  logic [7:0]  tx_d_o, rx_d_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  axi4 bus_if();

  uart_csr_fifo #(.REG_ADDR_MAP(BASE), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .divider_q_o(divider_q_o), .uart_config_q_o(cfg_q),
    .tx_enable_o(tx_enable_o), .rx_enable_o(rx_enable_o),
    .tx_d_o(tx_d_o), .tx_d_valid_o(tx_d_valid_o), .tx_d_ready_i(tx_d_ready_i),
    .rx_d_i(rx_d_i), .rx_d_valid_i(rx_d_valid_i), .rx_d_ready_o(rx_d_ready_o),
    .irq_o(irq_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] id, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus_if.aw_addr = addr; bus_if.aw_id = id; bus_if.aw_valid = 1'b1;
    bus_if.w_data = data; bus_if.w_strb = 4'hF; bus_if.w_last = 1'b1; bus_if.w_valid = 1'b1;
    #1; n = 0;
    while (!bus_if.aw_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("aw_ready", 32'(bus_if.aw_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.aw_valid = 1'b0; bus_if.w_valid = 1'b0;
    n = 0;
    while (!bus_if.b_valid && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", 32'(bus_if.b_valid), 32'd1);
    chk("b_id", 32'(bus_if.b_id), 32'(id));
    resp = bus_if.b_resp;
    bus_if.b_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus_if.ar_addr = addr; bus_if.ar_id = id; bus_if.ar_valid = 1'b1;
    #1; n = 0;
    while (!bus_if.ar_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("ar_ready", 32'(bus_if.ar_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.ar_valid = 1'b0;
    n = 0;
    while (!bus_if.r_valid && n < 50) begin @(negedge clk); n++; end
    chk("r_valid", 32'(bus_if.r_valid), 32'd1);
    chk("r_id", 32'(bus_if.r_id), 32'(id));
    chk("r_last", 32'(bus_if.r_last), 32'd1);
    data = bus_if.r_data;
    resp = bus_if.r_resp;
    bus_if.r_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.r_ready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off,
                        input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(BASE + off, 4'h5, d, r);
    chk({name, "_data"}, d, exp_data);
    chk({name, "_resp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic wr_chk(input string name, input logic [31:0] off,
                        input logic [31:0] data, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(BASE + off, data, 4'hA, r);
    chk({name, "_resp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_d_i = b; rx_d_valid_i = 1'b1;
    @(posedge clk); #1;
    rx_d_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          n;

    // Clock/reset and idle drive.
    bus_if.aw_valid = 1'b0; bus_if.w_valid = 1'b0; bus_if.ar_valid = 1'b0;
    bus_if.b_ready = 1'b0;  bus_if.r_ready = 1'b0;
    bus_if.aw_addr = '0; bus_if.aw_id = '0; bus_if.w_data = '0; bus_if.w_strb = '0;
    bus_if.w_last = 1'b0; bus_if.ar_addr = '0; bus_if.ar_id = '0;
    tx_d_ready_i = 1'b0; rx_d_valid_i = 1'b0; rx_d_i = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_b_valid", 32'(bus_if.b_valid), 32'd0);
    chk("rst_r_valid", 32'(bus_if.r_valid), 32'd0);
    chk("rst_tx_valid", 32'(tx_d_valid_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_divider", divider_q_o, 32'd0);
    chk("rx_ready_const", 32'(rx_d_ready_o), 32'd1);
    rst_n = 1'b1;

    vecs[0]  = '{1'b0, BASE + 32'h20, 32'h0,         2'b00, 32'h0200_0000};
    vecs[1]  = '{1'b0, BASE + 32'h00, 32'h0,         2'b00, 32'h0};
    vecs[2]  = '{1'b1, BASE + 32'h00, 32'h1234_5678, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, BASE + 32'h00, 32'h0,         2'b00, 32'h1234_5678};
    vecs[4]  = '{1'b0, BASE + 32'h14, 32'h0,         2'b00, 32'h1};
    vecs[5]  = '{1'b0, BASE + 32'h08, 32'h0,         2'b00, 32'h0};
    vecs[6]  = '{1'b0, BASE + 32'h24, 32'h0,         2'b00, 32'h0};
    vecs[7]  = '{1'b1, BASE + 32'h1C, 32'h3,         2'b00, 32'h0};
    vecs[8]  = '{1'b0, BASE + 32'h1C, 32'h0,         2'b00, 32'h3};
    vecs[9]  = '{1'b1, BASE + 32'h20, 32'hFFFF,      2'b10, 32'h0};
    vecs[10] = '{1'b1, BASE + 32'h14, 32'h3,         2'b10, 32'h0};
    vecs[11] = '{1'b0, BASE + 32'h28, 32'h0,         2'b10, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         2'b10, 32'h0};
    vecs[13] = '{1'b1, BASE + 32'h1000, 32'h1,       2'b10, 32'h0};
    vecs[14] = '{1'b0, BASE + 32'h04, 32'h0,         2'b10, 32'h0};
    vecs[15] = '{1'b1, BASE + 32'h04, 32'h9,         2'b10, 32'h0};
    vecs[16] = '{1'b0, BASE + 32'h0C, 32'h0,         2'b00, 32'h0};
    vecs[17] = '{1'b1, BASE + 32'h0C, 32'h0,         2'b00, 32'h0};
    vecs[18] = '{1'b1, BASE + 32'h02, 32'h7,         2'b10, 32'h0};

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, 4'(i), r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, 4'(i), d, r);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end
    end

    // CONTROL mode decode: {mode value, tx_en, rx_en}.
    chk("div_out", divider_q_o, 32'h1234_5678);
    chk("en_full_tx", 32'(tx_enable_o), 32'd1);
    chk("en_full_rx", 32'(rx_enable_o), 32'd1);
    wr_chk("ctl_simplex_slave", 32'h1C, 32'h1, 2'b00);
    chk("en_ss_tx", 32'(tx_enable_o), 32'd0);
    chk("en_ss_rx", 32'(rx_enable_o), 32'd1);
    wr_chk("ctl_simplex_master", 32'h1C, 32'h5, 2'b00);
    chk("cfg_out", cfg_q, 32'h5);
    chk("en_sm_tx", 32'(tx_enable_o), 32'd1);
    chk("en_sm_rx", 32'(rx_enable_o), 32'd0);
    wr_chk("ctl_half", 32'h1C, 32'h2, 2'b00);
    chk("en_half_tx", 32'(tx_enable_o), 32'd1);
    chk("en_half_rx", 32'(rx_enable_o), 32'd1);
    wr_chk("ctl_off", 32'h1C, 32'h0, 2'b00);
    chk("en_off_tx", 32'(tx_enable_o), 32'd0);
    chk("en_off_rx", 32'(rx_enable_o), 32'd0);

    // One TX byte with the transmitter stalled.
    wr_chk("tx_a5", 32'h10, 32'hA5, 2'b00);
    exp_q.push_back(8'hA5);
    rd_chk("txstatus_one", 32'h14, 32'h0, 2'b00);
    rd_chk("fifolvl_one", 32'h24, 32'h1, 2'b00);
    chk("tx_d_o_a5", 32'(tx_d_o), 32'hA5);
    chk("tx_valid_a5", 32'(tx_d_valid_o), 32'd1);

    // Fill to 16, then the 17th write must bounce.
    for (int i = 1; i < 16; i++) begin
      wr_chk($sformatf("tx_fill%0d", i), 32'h10, 32'(i), 2'b00);
      exp_q.push_back(8'(i));
    end
    wr_chk("tx_overflow", 32'h10, 32'h10, 2'b10);
    rd_chk("txstatus_full", 32'h14, 32'h2, 2'b00);
    rd_chk("fifolvl_full", 32'h24, 32'h10, 2'b00);
    rd_chk("txdata_last", 32'h10, 32'h0F, 2'b00);

    // Drain through the transmitter handshake.
    @(negedge clk);
    tx_d_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("tx_drain_valid%0d", i), 32'(tx_d_valid_o), 32'd1);
      chk($sformatf("tx_drain_data%0d", i), 32'(tx_d_o), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    tx_d_ready_i = 1'b0;
    chk("tx_drained_valid", 32'(tx_d_valid_o), 32'd0);
    rd_chk("txstatus_empty", 32'h14, 32'h1, 2'b00);

    // RX: 17 bytes into a 16-entry FIFO.
    for (int i = 0; i < 17; i++) begin
      rx_pulse(8'(i));
      if (i < 16) exp_q.push_back(8'(i));
    end
    rd_chk("rxstatus_ovr", 32'h08, 32'h7, 2'b00);
    rd_chk("fifolvl_rx", 32'h24, 32'h0010_0000, 2'b00);
    for (int i = 0; i < 16; i++)
      rd_chk($sformatf("rxdata%0d", i), 32'h04, 32'(exp_q.pop_front()), 2'b00);
    rd_chk("rxdata_empty", 32'h04, 32'h0, 2'b10);
    rd_chk("rxstatus_after", 32'h08, 32'h4, 2'b00);
    wr_chk("ovr_clear", 32'h08, 32'h4, 2'b00);
    rd_chk("rxstatus_clr", 32'h08, 32'h0, 2'b00);

    // Interrupt on RX not-empty.
    wr_chk("rxmask_set", 32'h0C, 32'h1, 2'b00);
    rx_pulse(8'h3C);
    chk("irq_push_edge", 32'(irq_o), 32'd0);
    @(posedge clk); #1;
`ifdef UART_CSR_IRQ_EN
    chk("irq_high", 32'(irq_o), 32'd1);
    rd_chk("rxmask_rb", 32'h0C, 32'h1, 2'b00);
`else
    chk("irq_tied", 32'(irq_o), 32'd0);
    rd_chk("rxmask_rb", 32'h0C, 32'h0, 2'b00);
`endif
    rd_chk("rx_3c", 32'h04, 32'h3C, 2'b00);
    @(posedge clk); #1;
    chk("irq_low", 32'(irq_o), 32'd0);

    // Write and read offered together: write goes first.
    @(negedge clk);
    bus_if.aw_addr = BASE; bus_if.aw_id = 4'h3; bus_if.w_data = 32'hCAFE;
    bus_if.w_valid = 1'b1; bus_if.aw_valid = 1'b1;
    bus_if.ar_addr = BASE; bus_if.ar_id = 4'h4; bus_if.ar_valid = 1'b1;
    #1;
    chk("arb_aw_ready", 32'(bus_if.aw_ready), 32'd1);
    chk("arb_ar_ready", 32'(bus_if.ar_ready), 32'd0);
    @(posedge clk); #1;
    bus_if.aw_valid = 1'b0; bus_if.w_valid = 1'b0;
    chk("arb_b_valid", 32'(bus_if.b_valid), 32'd1);
    chk("arb_b_resp", 32'(bus_if.b_resp), 32'd0);
    chk("arb_r_idle", 32'(bus_if.r_valid), 32'd0);
    bus_if.b_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.b_ready = 1'b0;
    n = 0;
    while (!bus_if.ar_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("arb_ar_late", 32'(bus_if.ar_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.ar_valid = 1'b0;
    chk("arb_r_valid", 32'(bus_if.r_valid), 32'd1);
    chk("arb_r_data", bus_if.r_data, 32'hCAFE);
    chk("arb_r_id", 32'(bus_if.r_id), 32'h4);
    bus_if.r_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.r_ready = 1'b0;

    // Reset while a write response is pending.
    wr_chk("pre_rst_ctl", 32'h1C, 32'h3, 2'b00);
    wr_chk("pre_rst_tx", 32'h10, 32'h77, 2'b00);
    rx_pulse(8'h11);
    chk("pre_rst_tx_valid", 32'(tx_d_valid_o), 32'd1);
    @(negedge clk);
    bus_if.aw_addr = BASE; bus_if.aw_id = 4'h6; bus_if.w_data = 32'h55;
    bus_if.aw_valid = 1'b1; bus_if.w_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.aw_valid = 1'b0; bus_if.w_valid = 1'b0;
    chk("mid_b_valid", 32'(bus_if.b_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.ar_addr = BASE; bus_if.ar_valid = 1'b1;
    #1;
    chk("rst_mid_b_valid", 32'(bus_if.b_valid), 32'd0);
    chk("rst_mid_ar_ready", 32'(bus_if.ar_ready), 32'd0);
    chk("rst_mid_divider", divider_q_o, 32'd0);
    chk("rst_mid_cfg", cfg_q, 32'd0);
    chk("rst_mid_tx_valid", 32'(tx_d_valid_o), 32'd0);
    chk("rst_mid_irq", 32'(irq_o), 32'd0);
    bus_if.ar_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_lvl", 32'h24, 32'h0, 2'b00);
    rd_chk("post_rst_txst", 32'h14, 32'h1, 2'b00);
    rd_chk("post_rst_rxst", 32'h08, 32'h0, 2'b00);
    rd_chk("post_rst_div", 32'h00, 32'h0, 2'b00);
    rd_chk("post_rst_txdata", 32'h10, 32'h0, 2'b00);
    rd_chk("post_rst_rxmask", 32'h0C, 32'h0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
